// File: rtl/cdb_pkg.sv
// Shared CDB definitions used by the arbiter, reservation stations, ROB and commit stage.
package cdb_pkg;

    localparam int unsigned CDB_NUM_FU = 4;
    localparam int unsigned CDB_TAG_W  = 2;
    localparam int unsigned CDB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU request/grant and CDB broadcast signals; master = FU/consumer side, slave = arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = $clog2(NUM_FU)
);
    logic [NUM_FU-1:0]        fu_req;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_grant;
    logic [TAG_W-1:0]         rob_head;
    logic                     flush;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [SRC_W-1:0]         cdb_src;
    logic [15:0]              busy_cycles;

    modport master (
        output fu_req, fu_tag, fu_data, rob_head, flush,
        input  fu_grant, cdb_valid, cdb_tag, cdb_data, cdb_src, busy_cycles
    );

    modport slave (
        input  fu_req, fu_tag, fu_data, rob_head, flush,
        output fu_grant, cdb_valid, cdb_tag, cdb_data, cdb_src, busy_cycles
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: first set request at or after i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    always_comb begin
        int unsigned j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!o_valid && i_req[IW'(j)]) begin
                o_valid           = 1'b1;
                o_grant[IW'(j)]   = 1'b1;
                o_idx             = IW'(j);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant, registered broadcast, busy-cycle counter.
// Define OLDEST_FIRST_EN to prioritise the requester whose tag is closest to the ROB head.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_FU = CDB_NUM_FU,
    parameter int unsigned TAG_W  = CDB_TAG_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    cdb_arbiter_if.slave   bus
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0] w_cand;
    logic [NUM_FU-1:0] w_req_eff;
    logic [NUM_FU-1:0] w_grant;
    logic [SRC_W-1:0]  w_idx;
    logic              w_any;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_data;

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic [SRC_W-1:0]  r_src;
    logic [SRC_W-1:0]  r_rr_ptr;
    logic [15:0]       r_busy;

`ifdef OLDEST_FIRST_EN
    // Keep only minimum-age requesters; rr_pick then breaks (illegal) ties round-robin.
    always_comb begin
        logic [TAG_W-1:0] age;
        logic [TAG_W-1:0] min_age;
        age     = '0;
        min_age = '1;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            age = bus.fu_tag[k*TAG_W +: TAG_W] - bus.rob_head;
            if (bus.fu_req[k] && age < min_age) min_age = age;
        end
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            age = bus.fu_tag[k*TAG_W +: TAG_W] - bus.rob_head;
            w_cand[k] = bus.fu_req[k] && (age == min_age);
        end
    end
`else
    assign w_cand = bus.fu_req;
`endif

    assign w_req_eff = (rst || bus.flush) ? '0 : w_cand;

    rr_pick #(
        .N  (NUM_FU),
        .IW (SRC_W)
    ) u_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    always_comb begin
        w_tag  = '0;
        w_data = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (w_grant[k]) begin
                w_tag  = bus.fu_tag[k*TAG_W +: TAG_W];
                w_data = bus.fu_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= '0;
            r_busy   <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_tag    <= w_tag;
                r_data   <= w_data;
                r_src    <= w_idx;
                r_rr_ptr <= (w_idx == SRC_W'(NUM_FU - 1)) ? '0 : w_idx + SRC_W'(1);
            end
            if (!bus.flush && ($countones(bus.fu_req) > 1) && (r_busy != '1))
                r_busy <= r_busy + 16'd1;
        end
    end

    assign bus.fu_grant    = w_grant;
    assign bus.cdb_valid   = r_valid;
    assign bus.cdb_tag     = r_tag;
    assign bus.cdb_data    = r_data;
    assign bus.cdb_src     = r_src;
    assign bus.busy_cycles = r_busy;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the single Common Data Bus (CDB) among the functional units that complete instructions in the Tomasulo core. Each cycle it accepts at most one result (ROB tag plus value) and broadcasts it, registered, to the ROB destination-value fields, the reservation stations and the commit stage. Fairness is round-robin, with an optional oldest-first (ROB-age) priority. A flush discards in-flight and pending broadcasts on misprediction or exception.

Parameters:
NUM_FU, 4, number of requesting functional units (2..8)
TAG_W, 2, ROB tag width; ROB depth is 2**TAG_W, and head/tag arithmetic wraps modulo that depth
DATA_W, 32, result value width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
fu_req  in  NUM_FU  per-FU result-ready request
fu_tag  in  NUM_FU*TAG_W  per-FU ROB tag; FU i occupies bits [i*TAG_W +: TAG_W]
fu_data  in  NUM_FU*DATA_W  per-FU result value; same packing scheme
fu_grant  out  NUM_FU  one-hot grant, combinational, same cycle as request
rob_head  in  TAG_W  current ROB head index (used only with OLDEST_FIRST_EN)
flush  in  1  discard all broadcasts
cdb_valid  out  1  broadcast valid, registered
cdb_tag  out  TAG_W  broadcast ROB tag, registered
cdb_data  out  DATA_W  broadcast value, registered
cdb_src  out  $clog2(NUM_FU)  index of the winning FU, registered
busy_cycles  out  16  count of cycles in which more than one FU requested (saturating)

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, busy_cycles=0, round-robin pointer rr_ptr=0. fu_grant is 0 while rst=1.
- Handshake:
  - An FU raises fu_req with stable tag/data and holds all three until it sees fu_grant[i]=1 at a rising edge.
  - The transfer completes on that edge; the FU may drop fu_req or present a new result in the next cycle.
  - Changing tag/data while a request is ungranted is illegal; the bench asserts this.
- Arbitration (combinational):
  - The winner is the first requesting FU scanning from rr_ptr upward, wrapping mod NUM_FU.
  - fu_grant is one-hot or zero; it is zero when there are no requests, or when flush=1 or rst=1.
- Pointer: on a grant, rr_ptr <= winner+1 mod NUM_FU. With no grant, rr_ptr holds.
- Latency: a request granted in cycle t appears on cdb_* in cycle t+1. cdb_valid=1 for exactly one cycle per grant.
- Throughput: 1 broadcast/cycle. Back-to-back grants to different FUs or to the same FU are allowed.
- Starvation bound: a continuously requesting FU is granted within NUM_FU cycles (round-robin mode only).
- No request: cdb_valid <= 0; cdb_tag, cdb_data and cdb_src hold their last values.
- Flush: when flush=1 in cycle t, no grant is issued in t and cdb_valid=0 in t+1. rr_ptr and busy_cycles are unaffected. FUs are expected to drop fu_req themselves.
- busy_cycles: increments when popcount(fu_req)>1 and no flush. Saturates at 16'hFFFF. Clears only on rst.
- Reset mid-operation: any pending grant is lost and outputs take their reset values at the next edge. FUs restart their requests.

Optional Feature:
OLDEST_FIRST_EN
- Defined:
  - The winner is the requester with the minimum age = (fu_tag - rob_head) mod 2**TAG_W, so results closer to commit broadcast first.
  - Equal ages (an illegal duplicate tag) resolve via round-robin order from rr_ptr. rr_ptr still updates as above.
  - The starvation bound does not apply.
- Undefined: rob_head is ignored and arbitration is pure round-robin.

Decomposition:
- Shared package cdb_pkg: TAG_W, DATA_W, the NUM_FU default, and a typedef cdb_bus_t {valid, tag, data}, shared by the reservation stations, the ROB and the commit stage.
- One sub-module, rr_pick: a pure-combinational rotating priority selector taking (req vector, pointer) and returning a one-hot output plus index. It is reused by the issue-select logic.

Test Plan:
1. Reset: rst=1 for 2 cycles with fu_req=4'b1111 -> fu_grant=0, cdb_valid=0, busy_cycles=0. After release, first grant goes to FU0 and cdb_tag equals FU0's tag at the next edge.
2. Single request: FU2 requests with tag=2'd3, data=32'hDEADBEEF -> fu_grant=4'b0100 the same cycle; next cycle cdb_valid=1, cdb_tag=3, cdb_data=32'hDEADBEEF, cdb_src=2.
3. All four FUs hold requests -> grants in order FU0, FU1, FU2, FU3 on consecutive cycles. busy_cycles increments 3 times (4, 3, 2 requesters; the last cycle has 1).
4. Flush: FU1 requesting with flush=1 -> fu_grant=0 and cdb_valid=0 next cycle. With flush=0 afterwards, FU1 is granted.
5. OLDEST_FIRST_EN: rob_head=2, FU0 tag=1, FU3 tag=2 -> FU3 is granted first (age 0), then FU0 (age 3).
6. Saturation: force busy_cycles to 16'hFFFE and hold 2 requesters for 3 cycles -> reads 16'hFFFF and stays there.
